// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding for the bit-serial serializer/deserializer pair
// Contents: state_t (ST_IDLE=1'b0, ST_SHIFT=1'b1), frame_len() helper.
package serial_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Bits on the wire for one word: data bits plus optional parity bit.
   function automatic int frame_len(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

endpackage

// File: rtl/piso_serializer_frame_counter.sv
// rtl/piso_serializer_frame_counter.sv - bit position counter for one serial frame
// Ports: clk, rst (sync, active-high), clr (sync clear), load/load_val (preset),
//        en (advance), count (current bit index), last_bit (count == FLEN-1).
// Counts 0..FLEN-1 and holds at FLEN-1; it never wraps.
module frame_counter #(
   parameter int FLEN = 8,
   parameter int CW   = $clog2(FLEN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          last_bit
);

   assign last_bit = (count == CW'(FLEN - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !last_bit) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with valid/ready load and gap-free framing
// Ports: clk, rst (sync, active-high); par_in[WIDTH], load_valid -> load_ready (accept handshake);
//        ser_out, ser_valid, frame_start, done (all change on posedge clk only).
// Optional: `define PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer
   import serial_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter int IDLE_LEVEL = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             done
);

`ifdef PISO_PARITY_EN
   localparam int FLEN = frame_len(WIDTH, 1'b1);
`else
   localparam int FLEN = frame_len(WIDTH, 1'b0);
`endif
   localparam int   CW       = $clog2(FLEN + 1);
   localparam logic IDLE_BIT = 1'(IDLE_LEVEL);

   state_t          state, state_nxt;
   logic [FLEN-1:0] shreg, shreg_nxt;
   logic [FLEN-1:0] frame;
   logic            ser_out_nxt;
   logic            frame_start_nxt;
   logic            done_nxt;
   logic [CW-1:0]   count;
   logic            last_bit;
   logic            accept;
   logic            cnt_en;
   logic            cnt_clr;

   // last_bit is only meaningful while shifting; in IDLE the counter sits at 0.
   assign load_ready = (state == ST_IDLE) || ((state == ST_SHIFT) && last_bit);
   assign accept     = load_valid && load_ready;
   assign ser_valid  = (state == ST_SHIFT);

   // Frame laid out so the bit to send first is always at the top; shifting left walks it out.
   always_comb begin
      frame = '0;
      for (int i = 0; i < WIDTH; i++) begin
         frame[FLEN-1-i] = (MSB_FIRST != 0) ? par_in[WIDTH-1-i] : par_in[i];
      end
`ifdef PISO_PARITY_EN
      frame[0] = ^par_in;
`endif
   end

   frame_counter #(
      .FLEN (FLEN),
      .CW   (CW)
   ) u_frame_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (accept),
      .load_val ('0),
      .en       (cnt_en),
      .count    (count),
      .last_bit (last_bit)
   );

   always_comb begin
      state_nxt       = state;
      shreg_nxt       = shreg;
      ser_out_nxt     = IDLE_BIT;
      frame_start_nxt = 1'b0;
      done_nxt        = 1'b0;
      cnt_en          = 1'b0;
      cnt_clr         = 1'b0;

      case (state)
         ST_IDLE: begin
            state_nxt = ST_IDLE;
         end
         ST_SHIFT: begin
            if (last_bit) begin
               state_nxt = ST_IDLE;
               cnt_clr   = 1'b1;
            end else begin
               cnt_en      = 1'b1;
               ser_out_nxt = shreg[FLEN-1];
               shreg_nxt   = {shreg[FLEN-2:0], 1'b0};
               // Next cycle shows the final bit of the frame.
               done_nxt    = (count == CW'(FLEN - 2));
            end
         end
      endcase

      // An accept (from IDLE or on the last bit) overrides everything: new frame starts next cycle.
      if (accept) begin
         state_nxt       = ST_SHIFT;
         ser_out_nxt     = frame[FLEN-1];
         shreg_nxt       = {frame[FLEN-2:0], 1'b0};
         frame_start_nxt = 1'b1;
         done_nxt        = 1'b0;
         cnt_en          = 1'b0;
         cnt_clr         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         ser_out     <= IDLE_BIT;
         frame_start <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nxt;
         shreg       <= shreg_nxt;
         ser_out     <= ser_out_nxt;
         frame_start <= frame_start_nxt;
         done        <= done_nxt;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (MSB-first and LSB-first instances)
module tb_piso_serializer;

   localparam int W    = 8;
   localparam logic IDLE = 1'b0;
`ifdef PISO_PARITY_EN
   localparam int FLEN = W + 1;
`else
   localparam int FLEN = W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] par_in = '0;
   logic         load_valid = 1'b0;

   logic ready_m, so_m, sv_m, fs_m, dn_m;
   logic ready_l, so_l, sv_l, fs_l, dn_l;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(0)) u_msb (
      .clk         (clk),
      .rst         (rst),
      .par_in      (par_in),
      .load_valid  (load_valid),
      .load_ready  (ready_m),
      .ser_out     (so_m),
      .ser_valid   (sv_m),
      .frame_start (fs_m),
      .done        (dn_m)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(0)) u_lsb (
      .clk         (clk),
      .rst         (rst),
      .par_in      (par_in),
      .load_valid  (load_valid),
      .load_ready  (ready_l),
      .ser_out     (so_l),
      .ser_valid   (sv_l),
      .frame_start (fs_l),
      .done        (dn_l)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: bits still to be shown for the current frame, and per-instance expected streams.
   int           rem    = 0;
   bit           mon_en = 1'b0;
   int           gap_pct = 0;
   logic [2:0]   q_m[$];
   logic [2:0]   q_l[$];
   logic [W-1:0] wq[$];

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] w);
      logic bm, bl, st, dn;
      for (int k = 0; k < FLEN; k++) begin
         if (k < W) begin
            bm = w[W-1-k];
            bl = w[k];
         end else begin
            bm = ^w;
            bl = ^w;
         end
         st = (k == 0);
         dn = (k == FLEN - 1);
         q_m.push_back({bm, st, dn});
         q_l.push_back({bl, st, dn});
      end
   endtask

   task automatic step();
      bit acc;
      acc = !rst && load_valid && (rem <= 1);
      @(posedge clk);
      if (rst) begin
         rem = 0;
         q_m.delete();
         q_l.delete();
      end else if (acc) begin
         push_frame(par_in);
         rem = FLEN;
      end else if (rem > 0) begin
         rem--;
      end
      mon_en = 1'b1;
      #1;
      if (acc) load_valid = 1'b0;
      if (!load_valid && !rst && wq.size() > 0 && $urandom_range(99) >= gap_pct) begin
         par_in     = wq.pop_front();
         load_valid = 1'b1;
      end
   endtask

   task automatic check_out(input string tag, input logic so, input logic sv, input logic fs,
                            input logic dn, input logic rdy, input bit have, input logic [2:0] e);
      chk({"ready_", tag}, rdy, rem <= 1);
      chk({"valid_", tag}, sv, rem > 0);
      if (sv === 1'b1) begin
         if (!have) begin
            checks++;
            errors++;
            $display("FAIL stream_%s: got valid bit expected none at %0t", tag, $time);
         end else begin
            chk({"bit_", tag},   so, e[2]);
            chk({"start_", tag}, fs, e[1]);
            chk({"done_", tag},  dn, e[0]);
         end
      end else begin
         chk({"idle_level_", tag}, so, IDLE);
         chk({"idle_start_", tag}, fs, 1'b0);
         chk({"idle_done_", tag},  dn, 1'b0);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [2:0] e;
      bit         have;
      if (mon_en) begin
         e = '0;
         have = 1'b0;
         if (sv_m === 1'b1 && q_m.size() > 0) begin
            e = q_m.pop_front();
            have = 1'b1;
         end
         check_out("m", so_m, sv_m, fs_m, dn_m, ready_m, have, e);
         e = '0;
         have = 1'b0;
         if (sv_l === 1'b1 && q_l.size() > 0) begin
            e = q_l.pop_front();
            have = 1'b1;
         end
         check_out("l", so_l, sv_l, fs_l, dn_l, ready_l, have, e);
      end
   end

   initial begin
      int c;
      // Reset for two cycles with no load request.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      // Single frames from idle, then back-to-back frames with load_valid held.
      gap_pct = 0;
      wq.push_back(8'hA5);
      repeat (FLEN + 4) step();
      wq.push_back(8'h01);
      repeat (FLEN + 4) step();
      wq.push_back(8'hA5);
      wq.push_back(8'h3C);
      repeat (2 * FLEN + 4) step();
      wq.push_back(8'h07);
      repeat (FLEN + 4) step();

      // Reset in the middle of a frame: the frame is dropped with no done pulse.
      wq.push_back(8'hFF);
      c = 0;
      step();
      while (rem != FLEN - 3 && c < 40) begin
         step();
         c++;
      end
      checks++;
      if (rem != FLEN - 3) begin
         errors++;
         $display("FAIL midframe_wait: got rem %0d expected %0d", rem, FLEN - 3);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();

      // Random words with random producer gaps, including many back-to-back hand-offs.
      gap_pct = 30;
      for (int i = 0; i < 60; i++) wq.push_back(W'($urandom));
      c = 0;
      while ((wq.size() > 0 || load_valid || rem > 0) && c < 3000) begin
         step();
         c++;
      end
      repeat (3) step();
      checks++;
      if (q_m.size() != 0 || q_l.size() != 0 || wq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d/%0d pending expected 0/0/0", q_m.size(), q_l.size(), wq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
